booth_dot_accumulator: RTL

Downstream stage of the 4×4 signed Booth multiplier: it consumes the multiplier's signed 8-bit `product` stream and sums a fixed number of products into a signed dot-product result. Each result is presented with a one-cycle `result_valid` pulse to the next consumer. Sits between the multiplier and result display/readout logic. It is purely sequential: it owns the group count and the partial sum, and reports overflow.

---
 rtl/booth_pkg.sv | 16 +
 rtl/booth_acc_adder.sv | 34 +++
 rtl/booth_dot_accumulator.sv | 98 +++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth dot-product accumulator
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PRODUCT_WIDTH = 8;

  function automatic int count_width(input int count);
    return $clog2(count);
  endfunction

endpackage

// File: rtl/booth_acc_adder.sv
// rtl/booth_acc_adder.sv - sign-extending adder with overflow detect; BOOTH_ACC_SATURATE_EN clamps on overflow
module booth_acc_adder
  import booth_pkg::*;
#(
  parameter int ACC_WIDTH = 12
) (
  input  logic [ACC_WIDTH-1:0]     partial,
  input  logic [PRODUCT_WIDTH-1:0] product,
  output logic [ACC_WIDTH-1:0]     product_ext,
  output logic [ACC_WIDTH-1:0]     sum,
  output logic                     overflow
);

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] raw;

  assign product_ext = ACC_WIDTH'($signed(product));
  assign raw         = partial + product_ext;

  // Same-sign operands producing an opposite-sign result is the only overflow case.
  assign overflow = (partial[ACC_WIDTH-1] == product_ext[ACC_WIDTH-1]) &&
                    (raw[ACC_WIDTH-1] != partial[ACC_WIDTH-1]);

`ifdef BOOTH_ACC_SATURATE_EN
  assign sum = overflow ? (partial[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX) : raw;
`else
  logic [2*ACC_WIDTH-1:0] sat_unused;
  assign sat_unused = {SAT_MAX, SAT_MIN};
  assign sum = raw;
`endif

endmodule

// File: rtl/booth_dot_accumulator.sv
// rtl/booth_dot_accumulator.sv - sums COUNT signed products per group; BOOTH_ACC_SATURATE_EN selects saturating adds
module booth_dot_accumulator
  import booth_pkg::*;
#(
  parameter int ACC_WIDTH = 12,
  parameter int COUNT     = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     product_valid,
  input  logic [PRODUCT_WIDTH-1:0] product,
  output logic [ACC_WIDTH-1:0]     acc_out,
  output logic                     result_valid,
  output logic                     overflow,
  output logic                     busy
);

  localparam int              CW   = count_width(COUNT);
  localparam logic [CW-1:0]   LAST = CW'(COUNT - 1);

  state_t               state;
  logic [CW-1:0]        count;
  logic [ACC_WIDTH-1:0] partial;
  logic                 overflow_run;
  logic [ACC_WIDTH-1:0] product_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 add_overflow;

  booth_acc_adder #(.ACC_WIDTH(ACC_WIDTH)) u_adder (
    .partial     (partial),
    .product     (product),
    .product_ext (product_ext),
    .sum         (sum),
    .overflow    (add_overflow)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      partial      <= '0;
      overflow_run <= 1'b0;
      acc_out      <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      // clear wins over a same-cycle product; the last completed result is kept.
      if (clear) begin
        state        <= IDLE;
        count        <= '0;
        partial      <= '0;
        overflow_run <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (product_valid) begin
              partial      <= product_ext;
              count        <= CW'(1);
              overflow_run <= 1'b0;
              state        <= ACCUM;
              busy         <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          ACCUM: begin
            if (product_valid) begin
              if (count == LAST) begin
                acc_out      <= sum;
                overflow     <= overflow_run | add_overflow;
                result_valid <= 1'b1;
                count        <= '0;
                partial      <= '0;
                overflow_run <= 1'b0;
                state        <= DONE;
                busy         <= 1'b0;
              end else begin
                partial      <= sum;
                count        <= count + CW'(1);
                overflow_run <= overflow_run | add_overflow;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
